modulo_avaliador_ataque: RTL and testbench



---
 rtl/modulo_avaliador_ataque_pkg.sv | 52 +++++
 rtl/modulo_debounce_pulso.sv | 54 +++++
 rtl/modulo_avaliador_ataque.sv | 133 +++++++++++++
 tb/tb_modulo_avaliador_ataque.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_avaliador_ataque_pkg.sv
// Shared constants for the attack evaluator: FSM encoding, game mode, shot results
// and the RGB LED colours.
package modulo_avaliador_ataque_pkg;

  localparam int unsigned N_COL  = 5;
  localparam int unsigned N_LIN  = 7;
  localparam int unsigned N_CELL = 35;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_SHOW = 2'd2,
    S_OVER = 2'd3
  } estado_t;

  typedef enum logic [1:0] {
    RES_HIT    = 2'd0,
    RES_MISS   = 2'd1,
    RES_REPEAT = 2'd2
  } resultado_t;

  localparam logic [1:0] MODE_ATTACK = 2'b10;

  // bit0 = green, bit1 = red
  localparam logic [1:0] RGB_OFF    = 2'b00;
  localparam logic [1:0] RGB_HIT    = 2'b01;
  localparam logic [1:0] RGB_MISS   = 2'b10;
  localparam logic [1:0] RGB_REPEAT = 2'b11;
  localparam logic [1:0] RGB_OVER   = 2'b10;

  // Number of ship cells in a position matrix.
  function automatic logic [5:0] popcount35(input logic [N_CELL-1:0] v);
    logic [5:0] soma;
    soma = 6'd0;
    for (int i = 0; i < int'(N_CELL); i++) begin
      soma = soma + {5'd0, v[i]};
    end
    return soma;
  endfunction

  function automatic logic [1:0] cor_resultado(input resultado_t r);
    logic [1:0] cor;
    case (r)
      RES_HIT:    cor = RGB_HIT;
      RES_MISS:   cor = RGB_MISS;
      RES_REPEAT: cor = RGB_REPEAT;
      default:    cor = RGB_OFF;
    endcase
    return cor;
  endfunction

endpackage

// File: rtl/modulo_debounce_pulso.sv
// Button conditioning: two-flop synchronizer, debounce on level changes and a single-cycle
// pulse on each accepted press. The button is active-low; internally everything is kept
// in "pressed = 1" polarity so that the all-zero reset state means "released".
module modulo_debounce_pulso #(
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            nivel_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ~btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed for DEB_CYCLES consecutive cycles.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      nivel_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync2_q == nivel_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        nivel_q <= sync2_q;
        cnt_q   <= '0;
        press_q <= sync2_q;  // releases flip the level but raise no event
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/modulo_avaliador_ataque.sv
// Attack evaluator: judges a confirmed shot against the position matrix, records it in
// the attack matrix, keeps hit/shot counts, shows the result on the RGB LED and flags
// game over once every ship cell has been hit. Single clock, synchronous reset.
module modulo_avaliador_ataque #(
  parameter int unsigned DEB_CYCLES  = 250000,
  parameter int unsigned SHOW_CYCLES = 25000000,
  parameter int unsigned N_COL       = 5,
  parameter int unsigned N_LIN       = 7
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        btn_confirm_n,
  input  logic [1:0]  mode,
  input  logic [2:0]  coord_col,
  input  logic [2:0]  coord_lin,
  input  logic [34:0] m_po,
  output logic [34:0] m_at,
  output logic [34:0] hit_mask,
  output logic [5:0]  hits,
  output logic [5:0]  shots,
  output logic [1:0]  rgb_output,
  output logic        game_over,
  output logic        busy
);

  import modulo_avaliador_ataque_pkg::*;

  localparam int unsigned ShowW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [ShowW-1:0] ShowMax = ShowW'(SHOW_CYCLES - 1);

  logic              press;
  estado_t           estado_q;
  logic [5:0]        idx_q;
  logic [34:0]       m_at_q, hit_q;
  logic [5:0]        hits_q, shots_q;
  logic [1:0]        rgb_q;
  logic [ShowW-1:0]  show_cnt_q;

  logic              coord_ok;
  logic [5:0]        idx_in;
  logic [5:0]        bit_sel;
  logic [5:0]        navios;
  resultado_t        res_eval;

  modulo_debounce_pulso #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk_i   (clk),
    .clr_i   (clr),
    .btn_n_i (btn_confirm_n),
    .press_o (press)
  );

  assign coord_ok = (coord_col < 3'(N_COL)) && (coord_lin < 3'(N_LIN));
  assign idx_in   = 6'(coord_lin) * 6'(N_COL) + 6'(coord_col);
  // Cell 0 (col 0, lin 0) lives in the MSB of the matrices.
  assign bit_sel  = 6'(N_CELL - 1) - idx_q;
  assign navios   = popcount35(m_po);

  // Classify the latched target for the EVAL cycle.
  always_comb begin
    res_eval = RES_MISS;
    if (m_at_q[bit_sel]) begin
      res_eval = RES_REPEAT;
    end else if (m_po[bit_sel]) begin
      res_eval = RES_HIT;
    end
  end

  // Main FSM with registered matrices, counters and LED colour.
  always_ff @(posedge clk) begin
    if (clr) begin
      estado_q   <= S_IDLE;
      idx_q      <= 6'd0;
      m_at_q     <= '0;
      hit_q      <= '0;
      hits_q     <= 6'd0;
      shots_q    <= 6'd0;
      rgb_q      <= RGB_OFF;
      show_cnt_q <= '0;
    end else begin
      case (estado_q)
        S_IDLE: begin
          if (press && (mode == MODE_ATTACK) && coord_ok) begin
            idx_q    <= idx_in;
            estado_q <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (res_eval != RES_REPEAT) begin
            m_at_q[bit_sel] <= 1'b1;
            shots_q         <= shots_q + 6'd1;
            if (res_eval == RES_HIT) begin
              hit_q[bit_sel] <= 1'b1;
              hits_q         <= hits_q + 6'd1;
            end
          end
          rgb_q      <= cor_resultado(res_eval);
          show_cnt_q <= ShowMax;
          estado_q   <= S_SHOW;
        end
        S_SHOW: begin
          if (show_cnt_q == '0) begin
            if ((hits_q == navios) && (navios != 6'd0)) begin
              rgb_q    <= RGB_OVER;
              estado_q <= S_OVER;
            end else begin
              rgb_q    <= RGB_OFF;
              estado_q <= S_IDLE;
            end
          end else begin
            show_cnt_q <= show_cnt_q - 1'b1;
          end
        end
        S_OVER: begin
          rgb_q <= RGB_OVER;
        end
        default: begin
          estado_q <= S_IDLE;
        end
      endcase
    end
  end

  assign m_at       = m_at_q;
  assign hit_mask   = hit_q;
  assign hits       = hits_q;
  assign shots      = shots_q;
  assign rgb_output = rgb_q;
  assign game_over  = (estado_q == S_OVER);
  assign busy       = (estado_q != S_IDLE);

endmodule

// File: tb/tb_modulo_avaliador_ataque.sv
// Self-checking bench for the attack evaluator with a scoreboard of expected shot results.
// SHOW is lengthened to 16 so a second debounced press can land inside the SHOW window.
module tb_modulo_avaliador_ataque;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SHOW = 16;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        btn_confirm_n = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [2:0]  coord_col = 3'd0;
  logic [2:0]  coord_lin = 3'd0;
  logic [34:0] m_po = '0;
  logic [34:0] m_at, hit_mask;
  logic [5:0]  hits, shots;
  logic [1:0]  rgb_output;
  logic        game_over, busy;

  modulo_avaliador_ataque #(
    .DEB_CYCLES  (DEB),
    .SHOW_CYCLES (SHOW),
    .N_COL       (5),
    .N_LIN       (7)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .btn_confirm_n (btn_confirm_n),
    .mode          (mode),
    .coord_col     (coord_col),
    .coord_lin     (coord_lin),
    .m_po          (m_po),
    .m_at          (m_at),
    .hit_mask      (hit_mask),
    .hits          (hits),
    .shots         (shots),
    .rgb_output    (rgb_output),
    .game_over     (game_over),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  rgb;
    logic [34:0] m_at;
    logic [34:0] hm;
    logic [5:0]  hits;
    logic [5:0]  shots;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Reference model of the game state.
  logic [34:0] mat_m = '0;
  logic [34:0] hm_m = '0;
  int          hits_m = 0;
  int          shots_m = 0;
  logic        over_m = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    mat_m = '0;
    hm_m = '0;
    hits_m = 0;
    shots_m = 0;
    over_m = 1'b0;
  endtask

  // Predict the outcome of a press and push it if it should be evaluated.
  task automatic model_shot(input logic [2:0] c, input logic [2:0] l, input logic [1:0] md);
    exp_t e;
    int   b;
    if (md == 2'b10 && c <= 3'd4 && l <= 3'd6 && !over_m) begin
      b = 34 - (int'(l) * 5 + int'(c));
      if (mat_m[b]) begin
        e.rgb = 2'b11;
      end else begin
        mat_m[b] = 1'b1;
        shots_m++;
        if (m_po[b]) begin
          hm_m[b] = 1'b1;
          hits_m++;
          e.rgb = 2'b01;
        end else begin
          e.rgb = 2'b10;
        end
      end
      e.m_at  = mat_m;
      e.hm    = hm_m;
      e.hits  = 6'(hits_m);
      e.shots = 6'(shots_m);
      sb_q.push_back(e);
      over_m = (hits_m == $countones(m_po)) && (m_po != '0);
    end
  endtask

  task automatic check_settled(input string tag);
    chk({tag, "_busy"}, busy, over_m);
    chk({tag, "_game_over"}, game_over, over_m);
    chk({tag, "_hits"}, hits, hits_m);
    chk({tag, "_shots"}, shots, shots_m);
    chk({tag, "_pending"}, sb_q.size(), 0);
  endtask

  task automatic shot(input string tag, input logic [2:0] c, input logic [2:0] l,
                      input logic [1:0] md, input int low);
    coord_col = c;
    coord_lin = l;
    mode      = md;
    model_shot(c, l, md);
    btn_confirm_n = 1'b0;
    tick(low);
    btn_confirm_n = 1'b1;
    tick(40);
    check_settled(tag);
  endtask

  task automatic do_reset(input string tag);
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    model_reset();
    chk({tag, "_m_at"}, m_at, 0);
    chk({tag, "_hit_mask"}, hit_mask, 0);
    chk({tag, "_hits"}, hits, 0);
    chk({tag, "_shots"}, shots, 0);
    chk({tag, "_rgb"}, rgb_output, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: a fresh result appears when the LED goes from off to a colour.
  logic [1:0] prev_rgb = 2'b00;
  logic       prev_go = 1'b0;
  logic       dur_on = 1'b0;
  logic [1:0] dur_rgb = 2'b00;
  int         dur = 0;

  always @(negedge clk) begin
    exp_t e;
    if (clr) begin
      prev_rgb = 2'b00;
      prev_go  = 1'b0;
      dur_on   = 1'b0;
    end else begin
      if (dur_on) begin
        if (rgb_output == dur_rgb && !game_over) begin
          dur++;
        end else begin
          chk("rgb_hold_cycles", dur, SHOW);
          dur_on = 1'b0;
        end
      end
      if (rgb_output != 2'b00 && prev_rgb == 2'b00 && !prev_go) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_eval", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("ev_rgb", rgb_output, e.rgb);
          chk("ev_m_at", m_at, e.m_at);
          chk("ev_hit_mask", hit_mask, e.hm);
          chk("ev_hits", hits, e.hits);
          chk("ev_shots", shots, e.shots);
        end
        dur_on  = 1'b1;
        dur     = 1;
        dur_rgb = rgb_output;
      end
      prev_rgb = rgb_output;
      prev_go  = game_over;
    end
  end

  initial begin
    logic any_busy;

    // Reset state
    tick(1);
    do_reset("reset");

    // Single-ship board: hit ends the game
    m_po = 35'h4_0000_0000;
    shot("hit", 3'd0, 3'd0, 2'b10, 10);
    chk("hit_over_rgb", rgb_output, 2'b10);
    // Presses in OVER are dropped
    shot("over_drop", 3'd1, 3'd0, 2'b10, 10);
    do_reset("reset2");

    // Miss then repeat on the same cell
    shot("miss", 3'd4, 3'd6, 2'b10, 10);
    shot("repeat", 3'd4, 3'd6, 2'b10, 10);
    chk("repeat_m_at", m_at, 35'h1);

    // Bouncy press: glitches shorter than DEB produce nothing
    coord_col = 3'd1;
    coord_lin = 3'd0;
    any_busy  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      btn_confirm_n = 1'b0;
      for (int k = 0; k < 3; k++) begin tick(1); any_busy |= busy; end
      btn_confirm_n = 1'b1;
      for (int k = 0; k < 2; k++) begin tick(1); any_busy |= busy; end
    end
    for (int k = 0; k < 10; k++) begin tick(1); any_busy |= busy; end
    chk("bounce_busy", any_busy, 0);
    chk("bounce_shots", shots, shots_m);
    shot("clean5", 3'd1, 3'd0, 2'b10, 5);

    // Rejected presses
    shot("rej_col", 3'd5, 3'd0, 2'b10, 10);
    shot("rej_lin", 3'd0, 3'd7, 2'b10, 10);
    shot("rej_mode", 3'd2, 3'd0, 2'b01, 10);

    // Second press landing inside SHOW is ignored
    coord_col = 3'd2;
    coord_lin = 3'd1;
    mode      = 2'b10;
    model_shot(3'd2, 3'd1, 2'b10);
    btn_confirm_n = 1'b0;
    tick(6);
    btn_confirm_n = 1'b1;
    tick(6);
    btn_confirm_n = 1'b0;
    tick(6);
    chk("show_press_busy", busy, 1);
    btn_confirm_n = 1'b1;
    tick(40);
    check_settled("show_press");

    // Reset in the third SHOW cycle
    coord_col = 3'd3;
    coord_lin = 3'd2;
    model_shot(3'd3, 3'd2, 2'b10);
    btn_confirm_n = 1'b0;
    tick(6);
    btn_confirm_n = 1'b1;
    for (int i = 0; i < 30 && rgb_output == 2'b00; i++) tick(1);
    chk("mid_show_seen", rgb_output != 2'b00, 1);
    tick(2);
    do_reset("mid_show_reset");
    shot("after_reset", 3'd0, 3'd0, 2'b10, 10);

    // Three-ship game over: (0,0) bit34, (2,3) bit17, (4,6) bit0
    do_reset("reset3");
    m_po = (35'h1 << 34) | (35'h1 << 17) | 35'h1;
    shot("go_ship1", 3'd0, 3'd0, 2'b10, 10);
    shot("go_water", 3'd1, 3'd1, 2'b10, 10);
    shot("go_ship2", 3'd2, 3'd3, 2'b10, 10);
    chk("go_hits2", hits, 2);
    chk("go_not_over", game_over, 0);
    shot("go_ship3", 3'd4, 3'd6, 2'b10, 10);
    chk("go_hits3", hits, 3);
    chk("go_shots4", shots, 4);
    chk("go_flag", game_over, 1);
    chk("go_rgb", rgb_output, 2'b10);

    tick(5);
    chk("final_pending", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
